alu: RTL and testbench
======================

Name: alu

Overview:
- Small multi-cycle 4-bit arithmetic unit for the processor datapath.
- A start strobe (init, qualified by sel) launches one of four operations on unsigned 4-bit operands A and B: add, subtract, multiply or divide.
- The result appears on a 6-bit bus with sign and carry/flag bits; done pulses when the result is valid.
- Multiply and divide are iterative, four iterations each.

Parameters:
- none (operand width fixed at 4, result width fixed at 6)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- init  input  1  start request, level-sampled in IDLE
- sel  input  1  enable; start accepted only when sel=1
- OP  input  2  operation: 0=ADD, 1=SUB, 2=MUL, 3=DIV
- A  input  4  operand A, unsigned
- B  input  4  operand B, unsigned
- resul  output  6  registered result
- Signo  output  1  result sign (SUB only)
- C_out  output  1  carry / overflow / error flag
- done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE; resul=0, Signo=0, C_out=0, done=0.
  - Aborts any operation in progress. Reset has priority over everything.
- States and transitions:
  - IDLE: if init=1 and sel=1 at an edge, go to LOAD.
  - LOAD: latch A, B, OP into internal registers; then ADD/SUB go to EXEC, MUL/DIV go to ITER.
  - EXEC: compute; results are written on the transition to DONE.
  - ITER: 4 cycles, using a 2-bit counter.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency, with the start accepted at edge N:
  - ADD/SUB: done high in the cycle following edge N+2.
  - MUL/DIV: done high in the cycle following edge N+6.
- Input changes:
  - A, B and OP may change freely after LOAD without affecting the operation in flight.
  - init is ignored outside IDLE.
  - If init is still high when DONE returns to IDLE, a new operation starts on the next edge (level-triggered).
- Result holding: resul, Signo and C_out are updated only on entry to DONE and hold until the next DONE or reset. done is 0 in every other state.
- ADD:
  - sum = A+B (5 bits); resul = {1'b0, sum}.
  - C_out = sum[4]; Signo = 0.
- SUB:
  - If A>=B: resul = A-B, Signo = 0.
  - Else: resul = B-A (magnitude), Signo = 1.
  - C_out = Signo (borrow).
  - resul[5:4] = 0.
- MUL:
  - Shift-add, one partial product per ITER cycle, LSB of B first; 8-bit internal accumulator.
  - resul = product[5:0]; C_out = 1 if product > 63, else 0; Signo = 0.
- DIV:
  - Restoring division, one quotient bit per ITER cycle.
  - If B != 0: resul = {2'b00, quotient[3:0]}, C_out = 0.
  - If B = 0: resul = 6'h3F and C_out = 1 (divide-by-zero); iterations still run and the latency is unchanged.
  - Signo = 0 for all DIV results.
- sel=0: init is ignored; the block stays in IDLE and outputs hold.

Test Plan:
- Reset, then ADD with OP=0, A=7, B=7, init pulsed 1 cycle -> done pulses exactly once 3 cycles later; resul=14, C_out=0, Signo=0. Also A=15, B=1 -> resul=16, C_out=1.
- SUB (OP=1): A=3, B=5 -> resul=2, Signo=1, C_out=1. Then A=6, B=2 -> resul=4, Signo=0, C_out=0. After done, resul holds while A and B change.
- MUL (OP=2): A=7, B=7 -> resul=49, C_out=0, done 7 cycles after start. Then A=15, B=15 -> resul=225 mod 64 = 33, C_out=1.
- DIV (OP=3): A=7, B=2 -> resul=3, C_out=0. Then A=5, B=0 -> resul=63, C_out=1.
- Sweep OP=0, A=0..7, B=0..7 with init pulses every 14 cycles -> every resul equals A+B, and exactly one done per pulse.
- Control cases:
  - init with sel=0 -> no done, outputs unchanged.
  - init re-asserted mid-MUL -> ignored, and the first result is correct.
  - rst asserted mid-DIV -> next cycle all outputs 0, no done.

Source files
------------

// File: rtl/alu.sv
// Multi-cycle 4-bit arithmetic unit: add, subtract, shift-add multiply and
// restoring divide. Operands are captured in LOAD. Result flags are
// registered on the EXEC -> DONE transition and held until the next result.
//
// state | meaning
// IDLE  | waiting for init with sel high
// LOAD  | capture A, B, OP and seed the iteration registers
// ITER  | one multiply/divide step per cycle, four cycles total
// EXEC  | form the result; it is written on the way into DONE
// DONE  | done high for one cycle
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       sel,
  input  logic [1:0] OP,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [5:0] resul,
  output logic       Signo,
  output logic       C_out,
  output logic       done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_ITER, S_DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  state_t     state, state_nxt;
  logic [1:0] op_r;
  logic [3:0] a_r, b_r;
  logic [1:0] iter_cnt;
  logic [7:0] acc, mcand;
  logic [3:0] mplier;
  logic [3:0] rem, quo;

  logic [4:0] div_shift, div_diff;
  logic       div_ge;
  logic [4:0] sum5;
  logic [5:0] res_nxt;
  logic       sgn_nxt, co_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; ITER exits when the down-counter reaches zero
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (init && sel) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = OP[1] ? S_ITER : S_EXEC;
      S_ITER:  if (iter_cnt == 2'd0) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One restoring-division step: bring in the next dividend bit, try subtracting
  always_comb begin
    div_shift = {rem, quo[3]};
    div_ge    = (div_shift >= {1'b0, b_r});
    div_diff  = div_shift - {1'b0, b_r};
  end

  // Operand capture and iterative multiply/divide datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= 2'd0;
      a_r      <= 4'd0;
      b_r      <= 4'd0;
      iter_cnt <= 2'd0;
      acc      <= 8'd0;
      mcand    <= 8'd0;
      mplier   <= 4'd0;
      rem      <= 4'd0;
      quo      <= 4'd0;
    end else if (state == S_LOAD) begin
      op_r     <= OP;
      a_r      <= A;
      b_r      <= B;
      iter_cnt <= 2'd3;
      acc      <= 8'd0;
      mcand    <= {4'd0, A};
      mplier   <= B;
      rem      <= 4'd0;
      quo      <= A;
    end else if (state == S_ITER) begin
      iter_cnt <= iter_cnt - 2'd1;
      if (op_r == OP_MUL) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= {mcand[6:0], 1'b0};
        mplier <= {1'b0, mplier[3:1]};
      end else begin
        // a zero divisor always "fits"; the result is overridden below
        rem <= div_ge ? div_diff[3:0] : div_shift[3:0];
        quo <= {quo[2:0], div_ge};
      end
    end
  end

  // Result and flag formation from the captured operands
  always_comb begin
    res_nxt = 6'd0;
    sgn_nxt = 1'b0;
    co_nxt  = 1'b0;
    sum5    = {1'b0, a_r} + {1'b0, b_r};
    case (op_r)
      OP_ADD: begin
        res_nxt = {1'b0, sum5};
        co_nxt  = sum5[4];
      end
      OP_SUB: begin
        if (a_r >= b_r) begin
          res_nxt = {2'b00, a_r - b_r};
        end else begin
          res_nxt = {2'b00, b_r - a_r};
          sgn_nxt = 1'b1;
        end
        co_nxt = sgn_nxt;
      end
      OP_MUL: begin
        res_nxt = acc[5:0];
        co_nxt  = |acc[7:6];
      end
      OP_DIV: begin
        if (b_r == 4'd0) begin
          res_nxt = 6'h3F;
          co_nxt  = 1'b1;
        end else begin
          res_nxt = {2'b00, quo};
        end
      end
      default: res_nxt = 6'd0;
    endcase
  end

  // Output registers load only on the EXEC -> DONE transition
  always_ff @(posedge clk) begin
    if (rst) begin
      resul <= 6'd0;
      Signo <= 1'b0;
      C_out <= 1'b0;
    end else if (state == S_EXEC) begin
      resul <= res_nxt;
      Signo <= sgn_nxt;
      C_out <= co_nxt;
    end
  end

  assign done = (state == S_DONE);

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, an ADD sweep, random
// operations against an arithmetic reference model, and control cases.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst, init, sel;
  logic [1:0] OP;
  logic [3:0] A, B;
  logic [5:0] resul;
  logic       Signo, C_out, done;

  int checks = 0;
  int failures = 0;

  alu dut (
    .clk(clk), .rst(rst), .init(init), .sel(sel), .OP(OP), .A(A), .B(B),
    .resul(resul), .Signo(Signo), .C_out(C_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int op, input int a, input int b,
                                output int res, output int sg, output int co);
    int p;
    res = 0; sg = 0; co = 0;
    case (op)
      0: begin p = a + b; res = p; co = (p > 15) ? 1 : 0; end
      1: begin
        if (a >= b) res = a - b;
        else begin res = b - a; sg = 1; end
        co = sg;
      end
      2: begin p = a * b; res = p % 64; co = (p > 63) ? 1 : 0; end
      default: begin
        if (b == 0) begin res = 63; co = 1; end
        else res = a / b;
      end
    endcase
  endfunction

  // Start one operation with a one-cycle init pulse and check latency,
  // result, flags, single-cycle done and absence of extra done pulses.
  task automatic do_op(input int op, input int a, input int b,
                       input bit scramble, input bit poke, input int pad);
    int er, es, ec, k, lat, extra;
    model(op, a, b, er, es, ec);
    lat = (op >= 2) ? 6 : 2;
    @(negedge clk);
    OP = 2'(op); A = 4'(a); B = 4'(b); sel = 1'b1; init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    @(posedge clk);
    if (scramble) begin
      @(negedge clk);
      A = 4'($urandom); B = 4'($urandom); OP = 2'($urandom);
    end
    k = 1;
    while (k < 12) begin
      @(posedge clk); #1;
      k++;
      if (poke && k == 3) init = 1'b1;
      if (poke && k == 4) init = 1'b0;
      if (done) break;
    end
    check("latency", 8'(k), 8'(lat));
    check("resul", {2'b00, resul}, 8'(er));
    check("Signo", {7'd0, Signo}, 8'(es));
    check("C_out", {7'd0, C_out}, 8'(ec));
    @(posedge clk); #1;
    check("done_pulse", {7'd0, done}, 8'd0);
    extra = 0;
    repeat (pad) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("no_extra_done", 8'(extra), 8'd0);
  endtask

  initial begin
    int k, nd, first, second;
    rst = 1'b1; init = 1'b0; sel = 1'b0; OP = 2'd0; A = 4'd0; B = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resul", {2'b00, resul}, 8'd0);
    check("rst_Signo", {7'd0, Signo}, 8'd0);
    check("rst_C_out", {7'd0, C_out}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(0, 7, 7, 0, 0, 2);
    do_op(0, 15, 1, 0, 0, 2);
    do_op(1, 3, 5, 0, 0, 2);
    do_op(1, 6, 2, 0, 0, 2);

    // result holds while operands move
    @(negedge clk);
    A = 4'd15; B = 4'd9; OP = 2'd2;
    repeat (4) @(posedge clk);
    #1;
    check("hold_resul", {2'b00, resul}, 8'd4);
    check("hold_Signo", {7'd0, Signo}, 8'd0);

    do_op(2, 7, 7, 0, 0, 2);
    do_op(2, 15, 15, 0, 0, 2);
    do_op(3, 7, 2, 0, 0, 2);
    do_op(3, 5, 0, 0, 0, 2);

    // sel low: init ignored, outputs hold (63 / C_out=1 from divide-by-zero)
    @(negedge clk);
    sel = 1'b0; init = 1'b1; OP = 2'd0; A = 4'd1; B = 4'd1;
    nd = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("sel0_no_done", 8'(nd), 8'd0);
    check("sel0_resul", {2'b00, resul}, 8'd63);
    check("sel0_C_out", {7'd0, C_out}, 8'd1);
    @(negedge clk);
    init = 1'b0; sel = 1'b1;

    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        do_op(0, a, b, 0, 0, 10);

    repeat (40)
      do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), 1, 0, 2);

    // init re-asserted during a multiply is ignored
    do_op(2, 13, 11, 1, 1, 8);

    // init held high across DONE restarts on the edge after returning to IDLE
    @(negedge clk);
    OP = 2'd0; A = 4'd3; B = 4'd4; sel = 1'b1; init = 1'b1;
    @(posedge clk);
    k = 0; nd = 0; first = 0; second = 0;
    repeat (10) begin
      @(posedge clk); #1;
      k++;
      if (k == 4) init = 1'b0;
      if (done) begin
        nd++;
        if (nd == 1) first = k;
        else second = k;
      end
    end
    check("level_count", 8'(nd), 8'd2);
    check("level_first", 8'(first), 8'd2);
    check("level_second", 8'(second), 8'd6);
    check("level_resul", {2'b00, resul}, 8'd7);

    // reset in the middle of a divide
    do_op(3, 9, 0, 0, 0, 2);
    @(negedge clk);
    OP = 2'd3; A = 4'd14; B = 4'd3; sel = 1'b1; init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_resul", {2'b00, resul}, 8'd0);
    check("midrst_Signo", {7'd0, Signo}, 8'd0);
    check("midrst_C_out", {7'd0, C_out}, 8'd0);
    check("midrst_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("midrst_no_done", 8'(nd), 8'd0);
    check("midrst_resul_hold", {2'b00, resul}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
